// File: rtl/puf_tune_ctrl.sv
// Successive-approximation calibration controller for an arbiter PUF.
// For each candidate tune level it lets the delay line settle, fires 2^S
// evaluations, counts the ones, and steps the level towards a 50% response rate.
module puf_tune_ctrl #(
    parameter int unsigned K        = 5,
    parameter int unsigned S        = 4,
    parameter int unsigned TOL      = 1,
    parameter int unsigned SETTLE   = 8,
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_resp_valid,
    input  logic         i_resp_bit,
    output logic [K-1:0] o_tune_level,
    output logic         o_trig,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_locked,
    output logic         o_err,
    output logic [S:0]   o_ones_count,
    output logic [2:0]   o_eval_count
);

    localparam int unsigned SAMPLES   = 1 << S;
    localparam int unsigned HALF      = 1 << (S - 1);
    localparam int unsigned TOL_LO    = (HALF > TOL) ? (HALF - TOL) : 0;
    localparam int unsigned TOL_HI    = HALF + TOL;
    localparam int unsigned LVL_INIT  = 1 << (K - 1);
    localparam int unsigned STEP_INIT = 1 << (K - 2);
    localparam int unsigned LVL_MAX   = (1 << K) - 1;
    localparam int unsigned CNT_MAX   = (SETTLE > WAIT_MAX) ? SETTLE : WAIT_MAX;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_TRIG,
        ST_WAIT,
        ST_EVAL,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [K-1:0]     r_tune_level;
    logic [K-1:0]     r_step;
    logic [S:0]       r_acc;
    logic [S:0]       r_samples;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trig;
    logic             r_busy;
    logic             r_done;
    logic             r_locked;
    logic             r_err;
    logic [S:0]       r_ones_count;
    logic [2:0]       r_eval_count;

    logic [K:0]       w_sum;
    logic [K-1:0]     w_lvl_up;
    logic [K-1:0]     w_lvl_dn;
    logic [S:0]       w_acc_next;
    logic [S:0]       w_samples_next;
    logic             w_in_tol;
    logic             w_above;

    // Saturating level arithmetic, sample accumulation and tolerance window
    always_comb begin
        w_sum          = {1'b0, r_tune_level} + {1'b0, r_step};
        w_lvl_up       = w_sum[K] ? K'(LVL_MAX) : w_sum[K-1:0];
        w_lvl_dn       = (r_step > r_tune_level) ? '0 : (r_tune_level - r_step);
        w_acc_next     = r_acc + (S+1)'(i_resp_bit);
        w_samples_next = r_samples + (S+1)'(1);
        w_in_tol       = (32'(r_acc) >= TOL_LO) && (32'(r_acc) <= TOL_HI);
        w_above        = 32'(r_acc) > TOL_HI;
    end

    // Calibration sequencer with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_tune_level <= K'(LVL_INIT);
            r_step       <= K'(STEP_INIT);
            r_acc        <= '0;
            r_samples    <= '0;
            r_cnt        <= '0;
            r_trig       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_ones_count <= '0;
            r_eval_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_locked     <= 1'b0;
                        r_err        <= 1'b0;
                        r_ones_count <= '0;
                        r_eval_count <= '0;
                        r_tune_level <= K'(LVL_INIT);
                        r_step       <= K'(STEP_INIT);
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE - 1)) begin
                        r_acc     <= '0;
                        r_samples <= '0;
                        r_trig    <= 1'b1;
                        r_state   <= ST_TRIG;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_TRIG: begin
                    r_trig  <= 1'b0;
                    r_cnt   <= CNT_W'(WAIT_MAX);
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i_resp_valid) begin
                        r_acc     <= w_acc_next;
                        r_samples <= w_samples_next;
                        if (w_samples_next == (S+1)'(SAMPLES)) begin
                            r_state <= ST_EVAL;
                        end else begin
                            r_trig  <= 1'b1;
                            r_state <= ST_TRIG;
                        end
                    end else if (r_cnt == CNT_W'(1)) begin
                        // No response within the window: give up, level untouched
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_EVAL: begin
                    r_ones_count <= r_acc;
                    r_eval_count <= r_eval_count + 3'(1);
                    if (w_in_tol) begin
                        r_locked <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (r_step == '0) begin
                        r_locked <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        // Too many ones means the top path is too fast: add delay
                        r_tune_level <= w_above ? w_lvl_up : w_lvl_dn;
                        r_step       <= r_step >> 1;
                        r_cnt        <= '0;
                        r_state      <= ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tune_level = r_tune_level;
    assign o_trig       = r_trig;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_locked     = r_locked;
    assign o_err        = r_err;
    assign o_ones_count = r_ones_count;
    assign o_eval_count = r_eval_count;

endmodule

// File: tb/tb_puf_tune_ctrl.sv
// Bench for puf_tune_ctrl: a PUF responder model with random latency drives the
// DUT, and a reference model recomputes the expected calibration outcome from
// the response bits actually delivered.
module tb_puf_tune_ctrl;

    localparam int K        = 5;
    localparam int S        = 4;
    localparam int TOL      = 1;
    localparam int SETTLE   = 8;
    localparam int WAIT_MAX = 64;
    localparam int SAMPLES  = 1 << S;
    localparam int HALF     = 1 << (S - 1);
    localparam int LVL_MAX  = (1 << K) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         resp_valid;
    logic         resp_bit;
    logic [K-1:0] tune_level;
    logic         trig;
    logic         busy;
    logic         done;
    logic         locked;
    logic         err;
    logic [S:0]   ones_count;
    logic [2:0]   eval_count;

    int total = 0;
    int bad   = 0;

    // Responder configuration: 0 alt, 1 all ones, 2 all zeros, 3 level-dependent, 4 random
    int mode    = 0;
    bit resp_en = 1'b0;
    bit alt     = 1'b0;
    int bits_q[$];
    int lvls_q[$];
    int trig_cnt = 0;
    int done_cnt = 0;

    puf_tune_ctrl #(
        .K(K), .S(S), .TOL(TOL), .SETTLE(SETTLE), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_resp_valid (resp_valid),
        .i_resp_bit   (resp_bit),
        .o_tune_level (tune_level),
        .o_trig       (trig),
        .o_busy       (busy),
        .o_done       (done),
        .o_locked     (locked),
        .o_err        (err),
        .o_ones_count (ones_count),
        .o_eval_count (eval_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit pick_bit(input int lvl);
        bit b;
        case (mode)
            0: begin b = alt; alt = ~alt; end
            1: b = 1'b1;
            2: b = 1'b0;
            3: begin
                if (lvl < 21) b = 1'b1;
                else if (lvl <= 23) begin b = alt; alt = ~alt; end
                else b = 1'b0;
            end
            default: b = ($urandom_range(1, 32) > lvl);
        endcase
        return b;
    endfunction

    // PUF responder: answers each trig after 1..4 cycles, only while in WAIT
    initial begin
        int cd;
        bit b;
        cd = 0;
        resp_valid = 1'b0;
        resp_bit   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cd = 0;
                resp_valid = 1'b0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    b = pick_bit(int'(tune_level));
                    resp_valid = 1'b1;
                    resp_bit   = b;
                    bits_q.push_back(int'(b));
                    lvls_q.push_back(int'(tune_level));
                end
            end else begin
                resp_valid = 1'b0;
                if (trig && resp_en) cd = $urandom_range(1, 4);
            end
        end
    end

    // Monitor: pulse counts and idle gap between a level change and the next trig
    initial begin
        int gap;
        bit armed;
        int prev;
        gap = 0;
        armed = 1'b0;
        prev = int'(tune_level);
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (trig) trig_cnt++;
            if (int'(tune_level) != prev && busy) begin
                gap = 1;
                armed = 1'b1;
            end else begin
                gap++;
            end
            if (trig && armed) begin
                chk("settle_gap", gap - 1, SETTLE);
                armed = 1'b0;
            end
            prev = int'(tune_level);
        end
    end

    // Global watchdog
    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // One calibration run; optionally pulses start again while busy
    task automatic run(input int m, input bit poke);
        int c;
        mode = m;
        resp_en = 1'b1;
        alt = 1'b0;
        bits_q.delete();
        lvls_q.delete();
        trig_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err_clr", err, 0);
        chk("start_eval_clr", eval_count, 0);
        c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
            start = (poke && (c == 40 || c == 100)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("busy_after", busy, 0);
    endtask

    // Reference model: replays the delivered bits through the halving search
    task automatic check_model(input string tag);
        int lvl, step, n, ones, idx, badlvl;
        bit lk, fin;
        lvl = 1 << (K - 1);
        step = 1 << (K - 2);
        n = 0; ones = 0; idx = 0; badlvl = 0;
        lk = 1'b0; fin = 1'b0;
        while (!fin && bits_q.size() >= idx + SAMPLES) begin
            ones = 0;
            for (int i = 0; i < SAMPLES; i++) begin
                ones += bits_q[idx + i];
                if (lvls_q[idx + i] != lvl) badlvl++;
            end
            n++;
            idx += SAMPLES;
            if (ones >= HALF - TOL && ones <= HALF + TOL) begin
                lk = 1'b1;
                fin = 1'b1;
            end else if (step == 0) begin
                fin = 1'b1;
            end else begin
                if (ones > HALF + TOL) lvl = (lvl + step > LVL_MAX) ? LVL_MAX : lvl + step;
                else lvl = (step > lvl) ? 0 : lvl - step;
                step = step / 2;
            end
        end
        chk({tag, "_complete"}, fin, 1);
        chk({tag, "_bits"}, bits_q.size(), n * SAMPLES);
        chk({tag, "_trigs"}, trig_cnt, n * SAMPLES);
        chk({tag, "_lvl_in_flight"}, badlvl, 0);
        chk({tag, "_eval_count"}, eval_count, n);
        chk({tag, "_locked"}, locked, lk);
        chk({tag, "_level"}, tune_level, lvl);
        chk({tag, "_ones"}, ones_count, ones);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int c;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", tune_level, 16);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_ones", ones_count, 0);
        chk("rst_eval", eval_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Alternating responses lock immediately
        run(0, 1'b0);
        check_model("alt");
        chk("alt_locked", locked, 1);
        chk("alt_level", tune_level, 16);
        chk("alt_eval", eval_count, 1);
        chk("alt_ones", ones_count, 8);

        // All ones climbs to the top and fails to lock
        run(1, 1'b1);
        check_model("ones");
        chk("ones_level", tune_level, 31);
        chk("ones_eval", eval_count, 5);
        chk("ones_locked", locked, 0);
        chk("ones_cnt", ones_count, 16);

        // All zeros walks to the bottom
        run(2, 1'b0);
        check_model("zeros");
        chk("zeros_level", tune_level, 1);
        chk("zeros_eval", eval_count, 5);
        chk("zeros_locked", locked, 0);

        // Level-dependent PUF converges to 22
        run(3, 1'b0);
        check_model("lvldep");
        chk("lvldep_level", tune_level, 22);
        chk("lvldep_eval", eval_count, 4);
        chk("lvldep_locked", locked, 1);

        // Timeout: no responses at all
        mode = 0;
        resp_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!trig && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("to_trig_seen", trig, 1);
        c = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("to_latency", c, WAIT_MAX + 1);
        chk("to_err", err, 1);
        chk("to_locked", locked, 0);
        chk("to_level", tune_level, 16);
        chk("to_eval", eval_count, 0);
        @(negedge clk);
        chk("to_err_hold", err, 1);
        chk("to_busy", busy, 0);

        // Next start clears err
        run(0, 1'b0);
        check_model("after_to");

        // Reset during WAIT of the second evaluation
        mode = 1;
        resp_en = 1'b1;
        bits_q.delete();
        lvls_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (bits_q.size() < SAMPLES + 2 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!trig && c < 20);
        chk("rr_trig_seen", trig, 1);
        @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rr_busy", busy, 0);
        chk("rr_trig", trig, 0);
        chk("rr_level", tune_level, 16);
        chk("rr_done", done, 0);
        chk("rr_eval", eval_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rr_no_done", done_cnt, d0);
        chk("rr_idle", busy, 0);

        run(2, 1'b0);
        check_model("after_rst");

        // Randomized PUF with random busy-time start pulses
        for (int r = 0; r < 8; r++) begin
            run(4, 1'($urandom_range(0, 1)));
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
